// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, MSB-first, with repeat passes and idle gaps
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       reps,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       S
);
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_SEND = 3'b001,
    ST_GAP  = 3'b010,
    ST_DONE = 3'b011
  } state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [3:0]       pass_q, pass_d, gap_q, gap_d;
  logic [LEN_W-1:0] len_eff;
  assign len_eff = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  // next-state logic; counters are tested for zero before any decrement so they never wrap
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SEND;
        pat_d   = pattern;
        len_d   = len_eff;
        idx_d   = len_eff - LEN_W'(1);
        pass_d  = reps;
        gap_d   = '0;
      end
      ST_SEND: if (abort) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        pass_d  = '0;
        gap_d   = '0;
      end else if (idx_q == '0) begin
        if (pass_q == '0) state_d = ST_DONE;
        else begin
          pass_d  = pass_q - 4'd1;
          idx_d   = len_q - LEN_W'(1);
          gap_d   = 4'(GAP - 1);
          state_d = (GAP == 0) ? ST_SEND : ST_GAP;
        end
      end else idx_d = idx_q - LEN_W'(1);
      ST_GAP: if (abort) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        pass_d  = '0;
        gap_d   = '0;
      end else if (gap_q == '0) state_d = ST_SEND;
      else gap_d = gap_q - 4'd1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      gap_q   <= gap_d;
    end
  end
  assign x     = (state_q == ST_SEND) & |(pat_q & (WIDTH'(1) << idx_q));
  assign valid = state_q == ST_SEND;
  assign busy  = state_q != ST_IDLE;
  assign done  = state_q == ST_DONE;
  assign S     = state_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: trace-expansion reference model plus directed and random stimulus for seq_gen
module tb_seq_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int GAP   = 1;
  logic             CLK = 0;
  logic             RESET = 0;
  logic             start = 0;
  logic             abort = 0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [3:0]       reps = '0;
  logic             x, valid, busy, done;
  logic [2:0]       S;
  int checks = 0;
  int errors = 0;

  seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP(GAP)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .reps(reps), .x(x), .valid(valid), .busy(busy), .done(done), .S(S)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] s;
    logic       x;
    logic       v;
    logic       b;
    logic       d;
  } obs_t;
  localparam obs_t IDLE_O = '0;
  obs_t q[$];
  obs_t cur = '0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model: a start expands into the full per-cycle output trace of the transfer
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q.delete();
      cur = IDLE_O;
    end else if (cur.s == 3'd0) begin
      if (start) begin
        int l;
        l = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
        for (int p = 0; p <= int'(reps); p++) begin
          for (int b = l - 1; b >= 0; b--) q.push_back({3'd1, pattern[b], 1'b1, 1'b1, 1'b0});
          if (p < int'(reps)) for (int g = 0; g < GAP; g++) q.push_back({3'd2, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        q.push_back({3'd3, 1'b0, 1'b0, 1'b1, 1'b1});
        cur = q.pop_front();
      end
    end else if (abort && (cur.s == 3'd1 || cur.s == 3'd2)) begin
      q.delete();
      cur = IDLE_O;
    end else cur = (q.size() != 0) ? q.pop_front() : IDLE_O;
  end

  always @(negedge CLK) if (RESET) chk("trace", {S, x, valid, busy, done}, cur);

  logic [2:0] det_sh;
  logic       det_flag;
  // bench-side 3-bit "101" detector fed from the serial output
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      det_sh   <= '0;
      det_flag <= 1'b0;
    end else begin
      det_sh   <= valid ? {det_sh[1:0], x} : 3'b0;
      det_flag <= valid && {det_sh[1:0], x} == 3'b101;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p;
    len = l;
    reps = r;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic capture(input int n, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bits = {bits[14:0], x};
      chk("cap_valid", valid, 1);
      if (i < n - 1) step();
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [11:0] xs, vs;
    step(2);
    chk("reset_out", {S, x, valid, busy, done}, 0);
    RESET = 1;
    step(2);
    chk("idle_out", {S, x, valid, busy, done}, 0);
    launch(8'hB7, 4'd8, 4'd0);
    capture(8, got);
    chk("single_bits", got, 16'h00B7);
    step();
    chk("single_done", done, 1);
    step();
    chk("single_idle_S", S, 0);
    chk("single_done_off", done, 0);
    step(2);
    launch(8'h05, 4'd3, 4'd2);
    xs = 12'b101010101010;
    vs = 12'b111011101110;
    for (int i = 1; i <= 12; i++) begin
      chk("rep_x", x, xs[12-i]);
      chk("rep_valid", valid, vs[12-i]);
      if (i == 4 || i == 8) chk("rep_gap_S", S, 3'b010);
      chk("rep_done", done, i == 12);
      if (i < 12) step();
    end
    step(3);
    launch(8'hA5, 4'd0, 4'd0);
    got = '0;
    for (int i = 1; i <= 8; i++) begin
      got = {got[14:0], x};
      if (i == 3) begin
        pattern = 8'h3C;
        len = 4'd4;
        start = 1;
      end else start = 0;
      step();
    end
    chk("len0_bits", got, 16'h00A5);
    chk("len0_done", done, 1);
    step(3);
    launch(8'hFF, 4'd8, 4'd0);
    step(3);
    abort = 1;
    step();
    abort = 0;
    chk("abort_S", S, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    got = '0;
    for (int i = 0; i < 10; i++) begin
      got[0] = got[0] | done;
      step();
    end
    chk("abort_nodone", got[0], 0);
    launch(8'h96, 4'd8, 4'd0);
    capture(8, got);
    chk("post_abort_bits", got, 16'h0096);
    step(3);
    launch(8'hC3, 4'd8, 4'd0);
    step(2);
    #2 RESET = 0;
    #1 chk("async_reset_out", {S, x, valid, busy, done}, 0);
    step();
    RESET = 1;
    step();
    launch(8'hC3, 4'd8, 4'd0);
    capture(8, got);
    chk("post_reset_bits", got, 16'h00C3);
    step();
    chk("post_reset_done", done, 1);
    step(3);
    launch(8'h05, 4'd3, 4'd0);
    chk("det_c1", det_flag, 0);
    step(2);
    chk("det_c3", det_flag, 0);
    chk("det_c3_valid", valid, 1);
    step();
    chk("det_c4", det_flag, 1);
    chk("det_c4_done", done, 1);
    step(3);
    for (int c = 0; c < 3000; c++) begin
      start   = $urandom_range(0, 3) == 0;
      abort   = $urandom_range(0, 24) == 0;
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      reps    = 4'($urandom_range(0, 3));
      step();
    end
    start = 0;
    abort = 0;
    step(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter that drives the one-bit `x` stream consumed by the lab's sequence-detector machines. It captures a parallel pattern on a start request. It then shifts the pattern out MSB-first, one bit per clock, optionally repeating it with idle gaps between passes. It reports its state on `S` so benches can correlate transmitter and detector state traces.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits. Legal range is 2..16.
- `LEN_W`, default 4: width of `len`. Must satisfy 2^LEN_W > WIDTH.
- `GAP`, default 1: number of idle cycles inserted between repeated passes. Legal range is 0..15.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit. Sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the current transfer.
- `pattern`  in  WIDTH  bits to send. Transmission starts at `pattern[len-1]` and ends at `pattern[0]`.
- `len`  in  LEN_W  number of bits per pass. A value of 0, or any value greater than WIDTH, means WIDTH.
- `reps`  in  4  number of extra passes. Total passes = `reps`+1.
- `x`  out  1  serial data bit.
- `valid`  out  1  high when `x` carries a pattern bit.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the final bit of the final pass.
- `S`  out  3  current state encoding.

## Operation
- State encodings: IDLE=000, SEND=001, GAP=010, DONE=011. Codes 100–111 are unreachable; if one is entered, the next state is IDLE.
- IDLE:
  - Outputs: `x`=0, `valid`=0, `busy`=0.
  - If `start`=1 at an edge, the block latches `pattern`, the effective `len`, and `reps` into internal registers, loads the bit index to len-1, loads the pass counter to `reps`, and moves to SEND.
- SEND:
  - Outputs: `x` = latched pattern[bit index], `valid`=1.
  - Each edge decrements the bit index.
  - At bit index 0, the next state depends on the pass counter:
    - pass counter ≠ 0: decrement the pass counter, reload the bit index to len-1, and go to GAP. If GAP=0, go directly to SEND.
    - pass counter = 0: go to DONE.
- GAP:
  - Outputs: `x`=0, `valid`=0.
  - The block stays in GAP for exactly GAP cycles, then returns to SEND.
- DONE:
  - Outputs: `done`=1, `x`=0, `valid`=0, `busy`=1.
  - Lasts exactly one cycle, then the state becomes IDLE unconditionally.
- `start` outside IDLE is ignored. Changes to `pattern`, `len`, or `reps` while busy have no effect on the transfer in progress.
- `abort`=1 in SEND or GAP: the next state is IDLE. No `done` pulse is produced and all counters are cleared. `abort` in IDLE or DONE has no effect.
- If `abort` and `start` are both asserted in IDLE, `start` wins.
- Counter widths: the bit index is LEN_W bits and the pass counter is 4 bits. Neither counter wraps, because the terminal conditions are checked before any decrement.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path exists from any input to any output.
- Reset values: `x`=0, `valid`=0, `busy`=0, `done`=0, `S`=000. All internal registers are cleared.
- Reset takes effect immediately on the falling edge of `RESET`, regardless of `CLK`. This includes reset mid-pass; the transfer is lost and no `done` is produced.
- For `start` sampled at edge 0:
  - The first bit is valid during cycle 1.
  - Pass p (p = 0..reps) occupies cycles 1 + p·(L+GAP) through p·(L+GAP) + L, where L is the effective length.
  - `done` is high during cycle (reps+1)·L + reps·GAP + 1.
  - IDLE is reached on the following edge.
- The earliest new `start` is accepted at the first edge after the state has returned to IDLE. Back-to-back transfers therefore have at least one IDLE cycle between them.

## Test plan
- Single pass: WIDTH=8, `pattern`=8'hB7, `len`=8, `reps`=0, `start` pulsed at edge 0.
  - Required: `x` = 1,0,1,1,0,1,1,1 in cycles 1–8 with `valid`=1.
  - Required: `done`=1 in cycle 9 only, and `S`=000 in cycle 10.
- Repeat with gap: GAP=1, `pattern`=8'h05, `len`=3, `reps`=2.
  - Required `x`/`valid` sequence: 101 / gap / 101 / gap / 101. During each gap, `S`=010 and `x`=0.
  - Required: `done` in cycle 12.
- Length defaults and start-while-busy: `len`=0 behaves exactly like `len`=8. A `start` pulse with a new pattern at cycle 4 is ignored, and the original bit sequence completes unchanged.
- Abort: `abort` asserted during the fourth bit of `pattern`=8'hFF.
  - Required: `S`=000, `valid`=0, and `busy`=0 on the next cycle.
  - Required: no `done` pulse; a following `start` transmits normally.
- Asynchronous reset mid-transfer: `RESET` driven low between clock edges during SEND.
  - Required: all outputs go to 0 immediately without waiting for a clock edge.
  - Required: after `RESET` is released, the first `start` produces the correct full sequence.
- Loopback: connect `x` to the serial input of the team's 3-bit detector. Send a pattern containing the detector's target sequence, and check that the detector flag asserts at the expected cycle relative to `valid`.
